// File: rtl/sieve_pkg.sv
// Shared definitions for the prime sieve pipeline: widths, first prime and scanner states.
package sieve_pkg;

    localparam int ADDR_W      = 10;
    localparam int CNT_W       = 8;
    localparam int FIRST_PRIME = 2;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } scan_state_t;

endpackage

// File: rtl/prime_fifo2.sv
// Two-entry synchronous FIFO with a registered head; push and pop may share a cycle.
module prime_fifo2 #(
    parameter int W = 10
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic [1:0]   count,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] head_q, head_d;
    logic [W-1:0] tail_q, tail_d;
    logic [1:0]   count_q, count_d;
    logic         do_pop;
    logic         do_push;

    // Next-state for the two storage slots; the head slot always holds the oldest entry.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        do_pop  = pop && (count_q != 2'd0);
        do_push = push && ((count_q != 2'd2) || do_pop);
        case ({do_push, do_pop})
            2'b10: begin
                if (count_q == 2'd0) begin
                    head_d = push_data;
                end else begin
                    tail_d = push_data;
                end
                count_d = 2'(count_q + 2'd1);
            end
            2'b01: begin
                head_d  = tail_q;
                count_d = 2'(count_q - 2'd1);
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    head_d = push_data;
                end else begin
                    head_d = tail_q;
                    tail_d = push_data;
                end
            end
            default: begin
            end
        endcase
    end

    // Storage and occupancy registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head  = head_q;
    assign count = count_q;
    assign full  = (count_q == 2'd2);
    assign empty = (count_q == 2'd0);

endmodule

// File: rtl/prime_scanner.sv
// Walks the sieve RAM from 2 to max_prime and streams unmarked indices out in order,
// using a one-deep read pipeline and a 2-entry buffer sized by read credits.
module prime_scanner #(
    parameter int ADDR_W     = sieve_pkg::ADDR_W,
    parameter int CNT_W      = sieve_pkg::CNT_W,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start_scan,
    input  logic [ADDR_W-1:0] max_prime,
    output logic              ram_rden,
    output logic [ADDR_W-1:0] ram_rdaddr,
    input  logic              ram_q,
    output logic              prime_valid,
    output logic [ADDR_W-1:0] prime_value,
    input  logic              prime_ready,
    output logic [CNT_W-1:0]  prime_count,
    output logic              busy,
    output logic              scan_done
);

    import sieve_pkg::*;

    scan_state_t       state_q, state_d;
    logic [ADDR_W-1:0] max_lat_q, max_lat_d;
    logic [ADDR_W:0]   next_idx_q, next_idx_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] ret_addr_q, ret_addr_d;
    logic [CNT_W-1:0]  prime_count_q, prime_count_d;

    logic              in_scan;
    logic              idx_left;
    logic              pop;
    logic              push;
    logic              issue;
    logic [2:0]        occupancy;
    logic              scan_finished;

    logic [ADDR_W-1:0] fifo_head;
    logic [1:0]        fifo_count;
    logic              fifo_full;
    logic              fifo_empty;

    prime_fifo2 #(
        .W(ADDR_W)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (push),
        .push_data(ret_addr_q),
        .pop      (pop),
        .head     (fifo_head),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Read issue and completion decode: a read is only issued if its result is guaranteed a slot.
    always_comb begin
        in_scan   = (state_q == SCAN);
        idx_left  = (next_idx_q <= {1'b0, max_lat_q});
        pop       = !fifo_empty && prime_ready;
        push      = inflight_q && !ram_q;
        occupancy = 3'(fifo_count) + 3'(inflight_q) - 3'(pop);
        issue     = in_scan && idx_left && (occupancy < 3'(FIFO_DEPTH));
        scan_finished = in_scan && !idx_left && !push && (fifo_empty || (pop && !fifo_full));
    end

    // FSM next state plus index, read-tracking and prime-count updates.
    always_comb begin
        state_d       = state_q;
        max_lat_d     = max_lat_q;
        next_idx_d    = next_idx_q;
        inflight_d    = issue;
        ret_addr_d    = ret_addr_q;
        prime_count_d = prime_count_q;
        if (issue) begin
            ret_addr_d = next_idx_q[ADDR_W-1:0];
            next_idx_d = next_idx_q + 1'b1;
        end
        if (pop) begin
            prime_count_d = prime_count_q + 1'b1;
        end
        case (state_q)
            IDLE: begin
                if (start_scan) begin
                    state_d       = SCAN;
                    max_lat_d     = max_prime;
                    next_idx_d    = (ADDR_W + 1)'(FIRST_PRIME);
                    prime_count_d = '0;
                end
            end
            SCAN: begin
                if (scan_finished) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            max_lat_q     <= '0;
            next_idx_q    <= '0;
            inflight_q    <= 1'b0;
            ret_addr_q    <= '0;
            prime_count_q <= '0;
        end else begin
            state_q       <= state_d;
            max_lat_q     <= max_lat_d;
            next_idx_q    <= next_idx_d;
            inflight_q    <= inflight_d;
            ret_addr_q    <= ret_addr_d;
            prime_count_q <= prime_count_d;
        end
    end

    assign ram_rden    = issue;
    assign ram_rdaddr  = issue ? next_idx_q[ADDR_W-1:0] : '0;
    assign prime_valid = !fifo_empty;
    assign prime_value = fifo_head;
    assign prime_count = prime_count_q;
    assign busy        = in_scan;
    assign scan_done   = (state_q == DONE);

endmodule
